// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    localparam int          ADDR_W          = 32;
    localparam int          INSTR_W         = 32;
    localparam logic [31:0] RESET_PC        = 32'h0000_0000;
    localparam int          MEM_LATENCY_MAX = 15;
    localparam int          CNT_W           = $clog2(MEM_LATENCY_MAX + 1);

    typedef enum logic {
        FETCH_IDLE,
        FETCH_WAIT
    } fetch_state_t;

    // How the PC register moves at the next edge.
    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD
    } pc_sel_t;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// rtl/instr_fetch_unit_pc_reg.sv - PC register with redirect alignment and INSTR_FETCH_ALIGN_CHECK_EN check
module pc_reg #(
    parameter int                ADDR_W   = fetch_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC[ADDR_W-1:0]
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    input  fetch_pkg::pc_sel_t sel,
    input  logic [ADDR_W-1:0] sel_val,
    output logic              load_ok,
    output logic [ADDR_W-1:0] load_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              misalign_err
);
    import fetch_pkg::*;

    // Redirect targets are always forced onto a word boundary.
    assign load_target = pc_load_val & {{(ADDR_W-2){1'b1}}, 2'b00};
    assign pc_plus4    = pc + ADDR_W'(4);

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    // A misaligned target is refused rather than rounded down.
    assign load_ok = pc_load && (pc_load_val[1:0] == 2'b00);

    // Sticky error: once a bad redirect is seen it stays set until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (pc_load && (pc_load_val[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end
`else
    assign load_ok      = pc_load;
    assign misalign_err = 1'b0;
`endif

    // PC update: hold, step to the next word, or take a redirect target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            case (sel)
                PC_INC:  pc <= pc_plus4;
                PC_LOAD: pc <= sel_val;
                default: pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch requester; optional INSTR_FETCH_ALIGN_CHECK_EN redirect check
module instr_fetch_unit #(
    parameter int                ADDR_W      = fetch_pkg::ADDR_W,
    parameter int                INSTR_W     = fetch_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC    = fetch_pkg::RESET_PC[ADDR_W-1:0],
    parameter int                MEM_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_req,
    output logic               fetch_ready,
    input  logic               flush,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_load_val,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus4,
    output logic               misalign_err
);
    import fetch_pkg::*;

    fetch_state_t       state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [INSTR_W-1:0] ir_d;
    logic               ir_valid_d;
    logic               pend_valid, pend_valid_d;
    logic [ADDR_W-1:0]  pend_pc, pend_pc_d;
    pc_sel_t            pc_sel;
    logic [ADDR_W-1:0]  pc_sel_val;
    logic               load_ok;
    logic [ADDR_W-1:0]  load_target;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_load      (pc_load),
        .pc_load_val  (pc_load_val),
        .sel          (pc_sel),
        .sel_val      (pc_sel_val),
        .load_ok      (load_ok),
        .load_target  (load_target),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .misalign_err (misalign_err)
    );

    assign fetch_ready = (state == FETCH_IDLE);

    // Next-state, address hold, IR capture and PC selection.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        addr_d       = imem_addr;
        ir_d         = ir;
        ir_valid_d   = 1'b0;
        pend_valid_d = pend_valid;
        pend_pc_d    = pend_pc;
        pc_sel       = PC_HOLD;
        pc_sel_val   = load_target;
        case (state)
            FETCH_IDLE: begin
                // A redirect in the same cycle as a request wins: fetch the new target.
                if (load_ok) begin
                    pc_sel = PC_LOAD;
                    addr_d = load_target;
                end
                if (fetch_req) begin
                    addr_d  = load_ok ? load_target : pc;
                    cnt_d   = CNT_W'(MEM_LATENCY - 1);
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                // Redirects while busy are parked; the newest one wins.
                if (load_ok) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = load_target;
                end
                if (flush) begin
                    state_d      = FETCH_IDLE;
                    pend_valid_d = 1'b0;
                    if (load_ok || pend_valid) begin
                        pc_sel     = PC_LOAD;
                        pc_sel_val = load_ok ? load_target : pend_pc;
                    end
                end else if (cnt == '0) begin
                    ir_d         = imem_instr;
                    ir_valid_d   = 1'b1;
                    state_d      = FETCH_IDLE;
                    pend_valid_d = 1'b0;
                    if (load_ok || pend_valid) begin
                        pc_sel     = PC_LOAD;
                        pc_sel_val = load_ok ? load_target : pend_pc;
                    end else begin
                        pc_sel = PC_INC;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH_IDLE;
            cnt        <= '0;
            imem_addr  <= RESET_PC;
            ir         <= '0;
            ir_valid   <= 1'b0;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            imem_addr  <= addr_d;
            ir         <= ir_d;
            ir_valid   <= ir_valid_d;
            pend_valid <= pend_valid_d;
            pend_pc    <= pend_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam int          L   = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req, flush, pc_load;
    logic [31:0] pc_load_val;
    logic        fetch_ready, ir_valid, misalign_err;
    logic [31:0] imem_addr, imem_instr, ir, pc, pc_plus4;

    int checks   = 0;
    int failures = 0;

    // Reference model: one transaction in flight, counted in remaining cycles.
    bit          m_busy;
    int          m_left;
    logic [31:0] m_addr, m_pc, m_ir, m_ptgt;
    bit          m_irv, m_pend, m_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ {a[15:0], a[31:16]};
    endfunction

    assign imem_instr = mem_word(imem_addr);

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W      (32),
        .INSTR_W     (32),
        .RESET_PC    (RPC),
        .MEM_LATENCY (L)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_req    (fetch_req),
        .fetch_ready  (fetch_ready),
        .flush        (flush),
        .pc_load      (pc_load),
        .pc_load_val  (pc_load_val),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .ir           (ir),
        .ir_valid     (ir_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .misalign_err (misalign_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_busy = 0; m_left = 0; m_addr = RPC; m_pc = RPC; m_ir = '0;
        m_irv = 0; m_pend = 0; m_ptgt = '0; m_err = 0;
    endfunction

    function automatic void model_edge(input bit fr, input bit fl, input bit ld, input logic [31:0] lv);
        bit          bad;
        bit          ok;
        logic [31:0] tgt;
        bad = ld && (lv % 4 != 0);
        ok  = ld && !(ALIGN_CHK && bad);
        tgt = lv - (lv % 4);
        if (ALIGN_CHK && bad) m_err = 1;
        m_irv = 0;
        if (!m_busy) begin
            if (ok) begin m_pc = tgt; m_addr = tgt; end
            if (fr) begin m_addr = m_pc; m_busy = 1; m_left = L; end
        end else begin
            if (ok) begin m_pend = 1; m_ptgt = tgt; end
            if (fl) begin
                m_busy = 0;
                if (m_pend) m_pc = m_ptgt;
                m_pend = 0;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_ir   = mem_word(m_addr);
                    m_irv  = 1;
                    m_busy = 0;
                    m_pc   = m_pend ? m_ptgt : m_pc + 32'd4;
                    m_pend = 0;
                end
            end
        end
    endfunction

    task automatic compare_all();
        check("fetch_ready",  {31'b0, fetch_ready},  {31'b0, !m_busy});
        check("imem_addr",    imem_addr,             m_addr);
        check("ir",           ir,                    m_ir);
        check("ir_valid",     {31'b0, ir_valid},     {31'b0, m_irv});
        check("pc",           pc,                    m_pc);
        check("pc_plus4",     pc_plus4,              m_pc + 32'd4);
        check("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
    endtask

    // One clock edge: sample the driven inputs, advance the model, compare after the edge.
    task automatic step();
        bit          fr, fl, ld;
        logic [31:0] lv;
        fr = fetch_req; fl = flush; ld = pc_load; lv = pc_load_val;
        @(posedge clk);
        model_edge(fr, fl, ld, lv);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        fetch_req = 0; flush = 0; pc_load = 0; pc_load_val = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        #2;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1;
        compare_all();
    endtask

    task automatic redirect(input logic [31:0] v);
        pc_load = 1; pc_load_val = v;
        step();
        pc_load = 0;
    endtask

    task automatic fetch_one();
        fetch_req = 1;
        step();
        fetch_req = 0;
        for (int i = 0; i < L; i++) step();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        #3;
        apply_reset();

        // First fetch from reset.
        fetch_one();
        check("first_ir", ir, 32'h2008_0005);
        check("first_pc", pc, 32'h4);

        // Four back-to-back fetches from reset.
        apply_reset();
        fetch_req = 1;
        for (int i = 0; i < 4 * (L + 1); i++) step();
        fetch_req = 0;
        check("b2b_pc", pc, 32'h10);
        check("b2b_ir", ir, mem_word(32'hC));

        // Redirect during the wait of the fetch at 8.
        redirect(32'h8);
        fetch_req = 1;
        step();
        fetch_req = 0;
        pc_load = 1; pc_load_val = 32'h40;
        step();
        pc_load = 0;
        for (int i = 1; i < L; i++) step();
        check("redir_ir", ir, mem_word(32'h8));
        check("redir_pc", pc, 32'h40);
        fetch_req = 1;
        step();
        fetch_req = 0;
        check("redir_next_addr", imem_addr, 32'h40);
        for (int i = 0; i < L; i++) step();

        // Flush one cycle after accepting.
        fetch_req = 1;
        step();
        fetch_req = 0;
        flush = 1;
        step();
        flush = 0;
        check("flush_ready", {31'b0, fetch_ready}, 32'd1);
        check("flush_ir", ir, mem_word(32'h40));
        check("flush_pc", pc, 32'h44);
        for (int i = 0; i < 3; i++) step();

        // Wrap-around at the top of the address space.
        redirect(32'hFFFF_FFFC);
        fetch_req = 1;
        step();
        fetch_req = 0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < L; i++) step();
        check("wrap_pc", pc, 32'h0);

        // Misaligned redirect.
        redirect(32'h22);
        for (int i = 0; i < 3; i++) step();
        if (ALIGN_CHK) begin
            check("misalign_pc", pc, 32'h0);
            check("misalign_err", {31'b0, misalign_err}, 32'd1);
        end else begin
            check("misalign_pc", pc, 32'h20);
            check("misalign_err", {31'b0, misalign_err}, 32'd0);
        end

        // Randomized traffic against the model.
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            fetch_req   = ($urandom_range(0, 1) == 1);
            flush       = ($urandom_range(0, 9) == 0);
            pc_load     = ($urandom_range(0, 7) == 0);
            pc_load_val = $urandom();
            if ($urandom_range(0, 3) != 0) pc_load_val[1:0] = 2'b00;
            step();
        end
        idle_inputs();

        // Reset in the middle of a fetch.
        for (int i = 0; i < L + 2; i++) step();
        fetch_req = 1;
        step();
        fetch_req = 0;
        rst_n = 0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1;
        compare_all();
        fetch_one();
        check("post_reset_ir", ir, 32'h2008_0005);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
